// File: rtl/cpu_defs_pkg.sv
// Shared definitions for the hardwired control unit: opcodes, instruction classes,
// sequencer state encoding and instruction field slices.
package cpu_defs;

    localparam int OP_W = 5;
    localparam int IR_W = 32;

    // Field positions inside the instruction register.
    localparam int OP_HI = 31;
    localparam int OP_LO = 27;
    localparam int RA_HI = 26;
    localparam int RA_LO = 23;
    localparam int RB_HI = 22;
    localparam int RB_LO = 19;
    localparam int RC_HI = 18;
    localparam int RC_LO = 15;

    localparam logic [OP_W-1:0] OP_ADD  = 5'b00011;
    localparam logic [OP_W-1:0] OP_SUB  = 5'b00100;
    localparam logic [OP_W-1:0] OP_SHR  = 5'b00101;
    localparam logic [OP_W-1:0] OP_SHRA = 5'b00110;
    localparam logic [OP_W-1:0] OP_SHL  = 5'b00111;
    localparam logic [OP_W-1:0] OP_ROR  = 5'b01000;
    localparam logic [OP_W-1:0] OP_AND  = 5'b01001;
    localparam logic [OP_W-1:0] OP_OR   = 5'b01010;
    localparam logic [OP_W-1:0] OP_ROL  = 5'b01011;
    localparam logic [OP_W-1:0] OP_MUL  = 5'b01111;
    localparam logic [OP_W-1:0] OP_DIV  = 5'b10000;
    localparam logic [OP_W-1:0] OP_NEG  = 5'b10001;
    localparam logic [OP_W-1:0] OP_NOT  = 5'b10010;
    localparam logic [OP_W-1:0] OP_NOP  = 5'b11010;
    localparam logic [OP_W-1:0] OP_HALT = 5'b11011;

    typedef enum logic [2:0] {
        CLS_BIN,
        CLS_MULDIV,
        CLS_UNARY,
        CLS_NOP,
        CLS_HALT
    } op_class_t;

    typedef enum logic [3:0] {
        S_RST,
        S_T0,
        S_T1,
        S_T2,
        S_T3,
        S_T4,
        S_T5,
        S_T6,
        S_HALT
    } state_t;

    function automatic logic [OP_W-1:0] op_field(input logic [IR_W-1:0] ir);
        return ir[OP_HI:OP_LO];
    endfunction

    function automatic logic [3:0] ra_field(input logic [IR_W-1:0] ir);
        return ir[RA_HI:RA_LO];
    endfunction

    function automatic logic [3:0] rb_field(input logic [IR_W-1:0] ir);
        return ir[RB_HI:RB_LO];
    endfunction

    function automatic logic [3:0] rc_field(input logic [IR_W-1:0] ir);
        return ir[RC_HI:RC_LO];
    endfunction

endpackage

// File: rtl/opcode_class.sv
// Combinational opcode-to-class map; unlisted opcodes fall through to NOP.
module opcode_class
    import cpu_defs::*;
(
    input  logic [OP_W-1:0] op,
    output op_class_t       cls
);

    always_comb begin
        case (op)
            OP_ADD, OP_SUB, OP_SHR, OP_SHRA, OP_SHL,
            OP_ROR, OP_AND, OP_OR, OP_ROL:       cls = CLS_BIN;
            OP_MUL, OP_DIV:                      cls = CLS_MULDIV;
            OP_NEG, OP_NOT:                      cls = CLS_UNARY;
            OP_HALT:                             cls = CLS_HALT;
            default:                             cls = CLS_NOP;
        endcase
    end

endmodule

// File: rtl/control_sequencer.sv
// Hardwired Moore control unit: fetch (T0-T2) then class-specific execute (T3-T6),
// driving every Datapath strobe from the state register and the IR opcode.
module control_sequencer
    import cpu_defs::*;
#(
    parameter int OPW = OP_W,
    parameter int IRW = IR_W
) (
    input  logic           Clock,
    input  logic           Clear,
    input  logic [IRW-1:0] IR,
    input  logic           Mem_Ready,
    input  logic           Stop,
    output logic           PC_Out,
    output logic           MDR_Out,
    output logic           ZLO_Out,
    output logic           ZHI_Out,
    output logic           PC_In,
    output logic           MDR_In,
    output logic           MAR_In,
    output logic           IR_In,
    output logic           Y_In,
    output logic           Z_In,
    output logic           HI_In,
    output logic           LO_In,
    output logic           IncPC,
    output logic           Read,
    output logic           Gra,
    output logic           Grb,
    output logic           Grc,
    output logic           R_In,
    output logic           R_Out,
    output logic [OPW-1:0] CONTROL,
    output logic           Run
);

    state_t          state, next_state;
    op_class_t       cls;
    logic [OPW-1:0]  op;
    logic            stop_pend;
    logic            ir_unused;

    // Register fields are consumed by the Datapath's select-encode logic, not here.
    assign op        = op_field(IR);
    assign ir_unused = ^IR[OP_LO-1:0];

    opcode_class u_opcode_class (
        .op  (op),
        .cls (cls)
    );

    // NOTE: sequential state uses non-blocking assignments and resets asynchronously,
    // so Clear drops every strobe without waiting for a clock edge.
    always_ff @(posedge Clock or posedge Clear) begin
        if (Clear) begin
            state     <= S_RST;
            stop_pend <= 1'b0;
        end else begin
            state <= next_state;
            if (Run && Stop)
                stop_pend <= 1'b1;
        end
    end

    // NOTE: every output and next_state gets a default first so no path infers a latch.
    always_comb begin
        next_state = state;
        PC_Out  = 1'b0;  MDR_Out = 1'b0;  ZLO_Out = 1'b0;  ZHI_Out = 1'b0;
        PC_In   = 1'b0;  MDR_In  = 1'b0;  MAR_In  = 1'b0;  IR_In   = 1'b0;
        Y_In    = 1'b0;  Z_In    = 1'b0;  HI_In   = 1'b0;  LO_In   = 1'b0;
        IncPC   = 1'b0;  Read    = 1'b0;
        Gra     = 1'b0;  Grb     = 1'b0;  Grc     = 1'b0;
        R_In    = 1'b0;  R_Out   = 1'b0;
        CONTROL = '0;
        Run     = 1'b0;

        unique case (state)
            S_RST: next_state = S_T0;
            S_T0: begin
                Run = 1'b1;
                PC_Out = 1'b1;  MAR_In = 1'b1;  IncPC = 1'b1;  Z_In = 1'b1;
                next_state = S_T1;
            end
            S_T1: begin
                // Strobes hold through memory wait states; reloading PC from ZLO is harmless.
                Run = 1'b1;
                ZLO_Out = 1'b1;  PC_In = 1'b1;  Read = 1'b1;  MDR_In = 1'b1;
                if (Mem_Ready)
                    next_state = S_T2;
            end
            S_T2: begin
                Run = 1'b1;
                MDR_Out = 1'b1;  IR_In = 1'b1;
                next_state = S_T3;
            end
            S_T3: begin
                Run = 1'b1;
                next_state = S_T4;
                unique case (cls)
                    CLS_BIN:    begin Grb = 1'b1; R_Out = 1'b1; Y_In = 1'b1; end
                    CLS_MULDIV: begin Gra = 1'b1; R_Out = 1'b1; Y_In = 1'b1; end
                    CLS_UNARY:  begin Grb = 1'b1; R_Out = 1'b1; Z_In = 1'b1; CONTROL = op; end
                    CLS_HALT:   next_state = S_HALT;
                    default:    next_state = (stop_pend || Stop) ? S_HALT : S_T0;
                endcase
            end
            S_T4: begin
                Run = 1'b1;
                next_state = S_T5;
                unique case (cls)
                    CLS_BIN:    begin Grc = 1'b1; R_Out = 1'b1; Z_In = 1'b1; CONTROL = op; end
                    CLS_MULDIV: begin Grb = 1'b1; R_Out = 1'b1; Z_In = 1'b1; CONTROL = op; end
                    CLS_UNARY: begin
                        ZLO_Out = 1'b1;  Gra = 1'b1;  R_In = 1'b1;
                        next_state = (stop_pend || Stop) ? S_HALT : S_T0;
                    end
                    default:    next_state = S_HALT;
                endcase
            end
            S_T5: begin
                Run = 1'b1;
                unique case (cls)
                    CLS_BIN: begin
                        ZLO_Out = 1'b1;  Gra = 1'b1;  R_In = 1'b1;
                        next_state = (stop_pend || Stop) ? S_HALT : S_T0;
                    end
                    CLS_MULDIV: begin
                        ZLO_Out = 1'b1;  LO_In = 1'b1;
                        next_state = S_T6;
                    end
                    default: next_state = S_HALT;
                endcase
            end
            S_T6: begin
                Run = 1'b1;
                ZHI_Out = 1'b1;  HI_In = 1'b1;
                next_state = (stop_pend || Stop) ? S_HALT : S_T0;
            end
            S_HALT:  next_state = S_HALT;
            default: next_state = S_RST;
        endcase
    end

endmodule

// File: tb/tb_control_sequencer.sv
// Directed bench for control_sequencer: per-cycle strobe signatures against
// hand-built expectations, covering fetch waits, Stop, halt and async Clear.
module tb_control_sequencer;

    logic        Clock, Clear, Mem_Ready, Stop;
    logic [31:0] IR;
    logic PC_Out, MDR_Out, ZLO_Out, ZHI_Out, PC_In, MDR_In, MAR_In, IR_In;
    logic Y_In, Z_In, HI_In, LO_In, IncPC, Read, Gra, Grb, Grc, R_In, R_Out, Run;
    logic [4:0]  CONTROL;
    logic [24:0] sig;

    int total = 0;
    int bad   = 0;
    int rd_cnt, ir_cnt;

    // Signature bit masks; the low five bits carry CONTROL.
    localparam logic [24:0] M_PC_OUT  = 25'd1 << 24;
    localparam logic [24:0] M_MDR_OUT = 25'd1 << 23;
    localparam logic [24:0] M_ZLO_OUT = 25'd1 << 22;
    localparam logic [24:0] M_ZHI_OUT = 25'd1 << 21;
    localparam logic [24:0] M_PC_IN   = 25'd1 << 20;
    localparam logic [24:0] M_MDR_IN  = 25'd1 << 19;
    localparam logic [24:0] M_MAR_IN  = 25'd1 << 18;
    localparam logic [24:0] M_IR_IN   = 25'd1 << 17;
    localparam logic [24:0] M_Y_IN    = 25'd1 << 16;
    localparam logic [24:0] M_Z_IN    = 25'd1 << 15;
    localparam logic [24:0] M_HI_IN   = 25'd1 << 14;
    localparam logic [24:0] M_LO_IN   = 25'd1 << 13;
    localparam logic [24:0] M_INCPC   = 25'd1 << 12;
    localparam logic [24:0] M_READ    = 25'd1 << 11;
    localparam logic [24:0] M_GRA     = 25'd1 << 10;
    localparam logic [24:0] M_GRB     = 25'd1 << 9;
    localparam logic [24:0] M_GRC     = 25'd1 << 8;
    localparam logic [24:0] M_R_IN    = 25'd1 << 7;
    localparam logic [24:0] M_R_OUT   = 25'd1 << 6;
    localparam logic [24:0] M_RUN     = 25'd1 << 5;

    localparam logic [24:0] E_IDLE = 25'd0;
    localparam logic [24:0] E_T0   = M_PC_OUT | M_MAR_IN | M_INCPC | M_Z_IN | M_RUN;
    localparam logic [24:0] E_T1   = M_ZLO_OUT | M_PC_IN | M_READ | M_MDR_IN | M_RUN;
    localparam logic [24:0] E_T2   = M_MDR_OUT | M_IR_IN | M_RUN;
    localparam logic [24:0] E_BIN3 = M_GRB | M_R_OUT | M_Y_IN | M_RUN;
    localparam logic [24:0] E_BIN4 = M_GRC | M_R_OUT | M_Z_IN | M_RUN;
    localparam logic [24:0] E_WB   = M_ZLO_OUT | M_GRA | M_R_IN | M_RUN;
    localparam logic [24:0] E_MD3  = M_GRA | M_R_OUT | M_Y_IN | M_RUN;
    localparam logic [24:0] E_MD4  = M_GRB | M_R_OUT | M_Z_IN | M_RUN;
    localparam logic [24:0] E_MD5  = M_ZLO_OUT | M_LO_IN | M_RUN;
    localparam logic [24:0] E_MD6  = M_ZHI_OUT | M_HI_IN | M_RUN;
    localparam logic [24:0] E_UN3  = M_GRB | M_R_OUT | M_Z_IN | M_RUN;
    localparam logic [24:0] E_NOP3 = M_RUN;

    assign sig = {PC_Out, MDR_Out, ZLO_Out, ZHI_Out, PC_In, MDR_In, MAR_In, IR_In,
                  Y_In, Z_In, HI_In, LO_In, IncPC, Read, Gra, Grb, Grc, R_In, R_Out,
                  Run, CONTROL};

    control_sequencer dut (
        .Clock(Clock), .Clear(Clear), .IR(IR), .Mem_Ready(Mem_Ready), .Stop(Stop),
        .PC_Out(PC_Out), .MDR_Out(MDR_Out), .ZLO_Out(ZLO_Out), .ZHI_Out(ZHI_Out),
        .PC_In(PC_In), .MDR_In(MDR_In), .MAR_In(MAR_In), .IR_In(IR_In),
        .Y_In(Y_In), .Z_In(Z_In), .HI_In(HI_In), .LO_In(LO_In),
        .IncPC(IncPC), .Read(Read), .Gra(Gra), .Grb(Grb), .Grc(Grc),
        .R_In(R_In), .R_Out(R_Out), .CONTROL(CONTROL), .Run(Run)
    );

    initial Clock = 1'b0;
    always #5 Clock = ~Clock;

    // Only one register may drive the bus in any cycle.
    always @(negedge Clock)
        assert ($countones({PC_Out, MDR_Out, ZLO_Out, ZHI_Out}) <= 1)
            else $error("bus contention sig=%h", sig);

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    // Advance one cycle, then compare the strobe signature mid-cycle.
    task automatic cyc(input string tag, input logic [24:0] exp);
        @(negedge Clock);
        if (Read)  rd_cnt++;
        if (IR_In) ir_cnt++;
        check(tag, {7'd0, sig}, {7'd0, exp});
    endtask

    task automatic restart();
        @(negedge Clock);
        Clear = 1'b1;
        @(negedge Clock);
        check("clear_idle", {7'd0, sig}, 32'd0);
        Clear = 1'b0;
        cyc("restart_t0", E_T0);
    endtask

    initial begin
        Clear = 1'b1; Mem_Ready = 1'b1; Stop = 1'b0; IR = 32'h4800_0000;
        rd_cnt = 0; ir_cnt = 0;
        repeat (2) @(negedge Clock);
        check("reset_sig", {7'd0, sig}, 32'd0);
        Clear = 1'b0;

        // and R0,R0,R0: six cycles, CONTROL only in T4
        cyc("and_t0", E_T0);
        cyc("and_t1", E_T1);
        cyc("and_t2", E_T2);
        cyc("and_t3", E_BIN3);
        cyc("and_t4", E_BIN4 | 25'b01001);
        cyc("and_t5", E_WB);
        cyc("and_next_t0", E_T0);

        // mul: LO in T5, HI in T6, next fetch at cycle 8
        IR = {5'b01111, 27'd0};
        cyc("mul_t1", E_T1);
        cyc("mul_t2", E_T2);
        cyc("mul_t3", E_MD3);
        cyc("mul_t4", E_MD4 | 25'b01111);
        cyc("mul_t5", E_MD5);
        cyc("mul_t6", E_MD6);
        cyc("mul_next_t0", E_T0);

        // add with three memory wait states: nine cycles total
        IR = {5'b00011, 4'd1, 4'd2, 4'd3, 15'd0};
        Mem_Ready = 1'b0;
        rd_cnt = 0; ir_cnt = 0;
        for (int i = 0; i < 4; i++) cyc("add_t1_wait", E_T1);
        Mem_Ready = 1'b1;
        cyc("add_t2", E_T2);
        cyc("add_t3", E_BIN3);
        cyc("add_t4", E_BIN4 | 25'b00011);
        cyc("add_t5", E_WB);
        check("add_read_cycles", rd_cnt, 4);
        check("add_ir_in_once", ir_cnt, 1);
        cyc("add_next_t0", E_T0);

        // neg with a one-cycle Stop pulse in T1: completes, then halts
        IR = {5'b10001, 27'd0};
        cyc("neg_t1", E_T1);
        Stop = 1'b1;
        cyc("neg_t2", E_T2);
        Stop = 1'b0;
        cyc("neg_t3", E_UN3 | 25'b10001);
        cyc("neg_t4", E_WB);
        cyc("neg_halt", E_IDLE);
        for (int i = 0; i < 20; i++) cyc("neg_stay_halted", E_IDLE);

        // halt opcode: T3 then HALT
        restart();
        IR = {5'b11011, 27'd0};
        cyc("halt_t1", E_T1);
        cyc("halt_t2", E_T2);
        cyc("halt_t3", E_NOP3);
        cyc("halt_state", E_IDLE);
        cyc("halt_state2", E_IDLE);

        // illegal opcode 11111 behaves as nop: back to T0 after four cycles
        restart();
        IR = {5'b11111, 27'd0};
        cyc("ill_t1", E_T1);
        cyc("ill_t2", E_T2);
        cyc("ill_t3", E_NOP3);
        cyc("ill_next_t0", E_T0);

        // asynchronous Clear in the middle of T4
        IR = 32'h4800_0000;
        cyc("clr_t1", E_T1);
        cyc("clr_t2", E_T2);
        cyc("clr_t3", E_BIN3);
        cyc("clr_t4", E_BIN4 | 25'b01001);
        #1 Clear = 1'b1;
        #1 check("clr_async_zero", {7'd0, sig}, 32'd0);
        @(negedge Clock);
        check("clr_held_zero", {7'd0, sig}, 32'd0);
        Clear = 1'b0;
        cyc("clr_restart_t0", E_T0);
        cyc("clr_restart_t1", E_T1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/control_sequencer.md
Name: control_sequencer

Overview:
- Hardwired control unit; sits directly upstream of the Phase 1 Datapath and drives every control strobe the Datapath currently receives from hand-written bench sequences.
- Runs the fetch cycle (T0–T2) and the execute cycles (T3–T6) for register-register ALU, multiply/divide, unary, nop and halt instructions.
- The Datapath performs register selection through Gra/Grb/Grc plus R_In/R_Out, with select-encode logic.

Parameters:
- OPW, 5, opcode field width (IR[31:27]).
- IRW, 32, instruction register width.

Ports:
- Clock  in  1  system clock, rising-edge.
- Clear  in  1  reset, asynchronous, active-high.
- IR  in  IRW  current instruction from the Datapath IR. Valid from the cycle after T2.
- Mem_Ready  in  1  memory has data on MData_In this cycle.
- Stop  in  1  request to halt after the current instruction.
- PC_Out, MDR_Out, ZLO_Out, ZHI_Out  out  1 each  bus drive enables.
- PC_In, MDR_In, MAR_In, IR_In, Y_In, Z_In, HI_In, LO_In  out  1 each  register load enables. Z_In loads ZHI and ZLO together.
- IncPC, Read  out  1 each  ALU PC+1 select; memory read strobe.
- Gra, Grb, Grc, R_In, R_Out  out  1 each  register-field select and general-register in/out.
- CONTROL  out  OPW  ALU operation code.
- Run  out  1  high while executing.

Behaviour:
- Moore machine. All outputs are decoded combinationally from the state register plus IR[31:27]. They are valid for the whole cycle and are sampled by the Datapath on the next rising edge.
- States: RST, T0, T1, T2, T3, T4, T5, T6, HALT.
- While Clear=1: state=RST, stop_pend=0, all outputs 0, CONTROL=0, Run=0.
- RST: outputs 0, Run=0; goes to T0 on the first edge after Clear falls.
- T0: PC_Out, MAR_In, IncPC, Z_In; CONTROL=0. Next state T1.
- T1: ZLO_Out, PC_In, Read, MDR_In.
  - Stays in T1 while Mem_Ready=0, with the strobes held; reloading PC from ZLO is idempotent.
  - Goes to T2 when Mem_Ready=1.
- T2: MDR_Out, IR_In. Next state T3 unconditionally.
- Classes by IR[31:27]:
  - BIN: add 00011, sub 00100, shr 00101, shra 00110, shl 00111, ror 01000, rol 01001? no — and 01001, or 01010, rol 01011, ror 01000.
  - MULDIV: mul 01111, div 10000.
  - UNARY: neg 10001, not 10010.
  - NOP: nop 11010, plus every unlisted opcode.
  - HALT: halt 11011.
- BIN: T3 Grb, R_Out, Y_In. T4 Grc, R_Out, Z_In, CONTROL=opcode. T5 ZLO_Out, Gra, R_In. Then end.
- MULDIV: T3 Gra, R_Out, Y_In. T4 Grb, R_Out, Z_In, CONTROL=opcode. T5 ZLO_Out, LO_In. T6 ZHI_Out, HI_In. Then end.
- UNARY: T3 Grb, R_Out, Z_In, CONTROL=opcode. T4 ZLO_Out, Gra, R_In. Then end.
- NOP: T3 asserts nothing. Then end.
- HALT: T3 asserts nothing. Next state HALT.
- End of instruction: go to HALT if stop_pend=1 or Stop=1, otherwise go to T0.
- HALT: all outputs 0, Run=0. Only Clear leaves HALT.
- CONTROL=0 in every cycle except the Z_In cycle of an execute sequence.
- Run=1 in T0–T6.
- stop_pend:
  - Set when Stop=1 on any edge in T0–T6.
  - Stays set until Clear.
  - A Stop pulse of one cycle is never lost.
  - A Stop raised during T1 wait states does not abort the fetch; the instruction completes.
- At most one bus driver is active per cycle. This is an assertion in the bench.
- Clear mid-instruction forces RST immediately and deasserts all strobes asynchronously.
- Instruction latency in cycles, excluding T1 waits: BIN 6, MULDIV 7, UNARY 5, NOP 4.

Decomposition:
- Package cpu_defs holds:
  - opcode constants
  - the class enum (BIN/MULDIV/UNARY/NOP/HALT)
  - the state encoding
  - the field slices OP=IR[31:27], RA=IR[26:23], RB=IR[22:19], RC=IR[18:15]
- Sub-module opcode_class: combinational map from opcode to class. It is shared later with the ld/st/branch extension.

Test Plan:
- Clear pulse, then IR=32'h4800_0000 (and R0,R0,R0), Mem_Ready=1 → T0..T5 in 6 cycles; CONTROL=5'b01001 only in T4; Gra+R_In in T5; back to T0; Run=1 throughout.
- mul (IR[31:27]=01111) → LO_In in T5, HI_In in T6, ZHI_Out only in T6; next T0 at cycle 8.
- Mem_Ready held low 3 cycles in T1 → Read/MDR_In high for 4 cycles; IR_In exactly once; total 9 cycles for BIN.
- 1-cycle Stop pulse in T1 of a neg instruction → instruction completes (R_In in T4); then HALT, Run=0; stays halted 20 cycles.
- halt opcode 11011 → HALT after T3; illegal opcode 11111 → behaves as nop, T0 after 4 cycles.
- Clear asserted asynchronously mid-T4 → all outputs 0 before the next edge; restarts at T0 one cycle after release.
